// File: rtl/text_mem_arbiter.sv
// Single-port text memory arbiter: the renderer's character fetch gets its fixed slot;
// other cycles go to the clear-screen sequencer first, then to buffered CPU writes.
module text_mem_arbiter #(
    parameter int unsigned COLS       = 40,
    parameter int unsigned ROWS       = 30,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [9:0]  pixh,
    input  logic [9:0]  pixv,
    input  logic        cpu_wr_valid,
    input  logic [11:0] cpu_wr_addr,
    input  logic [7:0]  cpu_wr_data,
    output logic        cpu_wr_ready,
    input  logic        cpu_cls,
    output logic        busy,
    output logic        mem_en,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  render_ascii,
    output logic        render_valid
);

    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 8;
    localparam int unsigned PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_entry_t;

    wr_entry_t     fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          cls_active;
    logic [AW-1:0] cls_cnt;
    logic          slot_d1;

    logic          visible;
    logic          slot;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic [AW-1:0] render_addr;
    logic          full;
    logic          push;
    logic          pop;
    logic          cls_step;
    wr_entry_t     head;
    logic          unused_pixv_low;

    // Render slot: one fetch per 16-pixel cell, at pixel 14 so data lands before the next cell
    assign visible     = (pixh < 10'd640) && (pixv < 10'd480);
    assign slot        = visible && (pixh[3:0] == 4'd14);
    assign row         = AW'(pixv[9:4]);
    assign col         = AW'(pixh[9:4]);
    assign render_addr = col + (row << 5) + (row << 3);
    assign unused_pixv_low = ^pixv[3:0];

    assign full         = (count == CW'(FIFO_DEPTH));
    assign cpu_wr_ready = !full;
    assign push         = cpu_wr_valid && !full;
    assign cls_step     = !slot && cls_active;
    // No pop on a clear pulse: the head belongs to the batch being flushed
    assign pop          = !slot && !cls_active && !cpu_cls && (count != '0);
    assign head         = fifo_q[rd_ptr];
    assign busy         = cls_active || (count != '0);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (slot) begin
            mem_en   = 1'b1;
            mem_addr = render_addr;
        end else if (cls_active) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cls_cnt;
            mem_wdata = FILL_CHAR;
        end else if (pop && (head.addr < AW'(CELLS))) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = head.addr;
            mem_wdata = head.data;
        end
    end

    // Write buffer storage; a clear pulse restarts the buffer at entry 0
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[cpu_cls ? PW'(0) : wr_ptr] <= {cpu_wr_addr, cpu_wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            cls_active   <= 1'b0;
            cls_cnt      <= '0;
            slot_d1      <= 1'b0;
            render_valid <= 1'b0;
            render_ascii <= '0;
        end else begin
            slot_d1      <= slot;
            render_valid <= slot_d1;
            if (slot_d1) begin
                render_ascii <= mem_rdata;
            end

            if (cpu_cls) begin
                // Flush first, then keep a same-cycle write as the sole entry
                rd_ptr     <= '0;
                wr_ptr     <= push ? PW'(1) : PW'(0);
                count      <= CW'(push);
                cls_active <= 1'b1;
                cls_cnt    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
                if (cls_step) begin
                    if (cls_cnt == AW'(CELLS - 1)) begin
                        cls_active <= 1'b0;
                        cls_cnt    <= '0;
                    end else begin
                        cls_cnt <= cls_cnt + AW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_text_mem_arbiter.sv
// Scoreboard bench for text_mem_arbiter: directed stimulus pushes expected memory writes
// and render strobes; a negedge monitor pops and compares them as the DUT produces them.
module tb_text_mem_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic [9:0]  pixh;
    logic [9:0]  pixv;
    logic        cpu_wr_valid;
    logic [11:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_wr_ready;
    logic        cpu_cls;
    logic        busy;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  render_ascii;
    logic        render_valid;

    text_mem_arbiter dut (
        .clk          (clk),
        .clr          (clr),
        .pixh         (pixh),
        .pixv         (pixv),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_wr_ready (cpu_wr_ready),
        .cpu_cls      (cpu_cls),
        .busy         (busy),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .render_ascii (render_ascii),
        .render_valid (render_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int due;
    } wexp_t;

    typedef struct {
        int data;
        int due;
    } rexp_t;

    wexp_t      wq[$];
    rexp_t      rq[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] exp_rchar = 8'h00;
    logic       mem_init;
    logic [7:0] mem [0:1199];

    always @(posedge clk) cyc <= cyc + 1;

    // Display memory block: synchronous read, one-cycle latency
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1200; i++) mem[i] <= 8'h00;
            mem[41] <= 8'h41;
        end else if (mem_en) begin
            if (mem_we) begin
                if (mem_addr < 12'd1200) mem[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= (mem_addr < 12'd1200) ? mem[mem_addr] : 8'h00;
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: compare every DUT write and render strobe against the scoreboard queues
    always @(negedge clk) begin
        wexp_t w;
        rexp_t r;
        if (mem_en && mem_we) begin
            if (wq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %0d expected none (cycle %0d)",
                         mem_addr, mem_wdata, cyc);
            end else begin
                w = wq.pop_front();
                check("wr_addr", int'(mem_addr), w.addr);
                check("wr_data", int'(mem_wdata), w.data);
                if (w.due >= 0) check("wr_cycle", cyc, w.due);
            end
        end
        if (render_valid) begin
            if (rq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_render: got %0d expected none (cycle %0d)", render_ascii, cyc);
            end else begin
                r = rq.pop_front();
                check("render_ascii", int'(render_ascii), r.data);
                check("render_cycle", cyc, r.due);
            end
        end
        // Every visible cell's slot owes one render strobe two cycles later
        if (clr && pixh < 10'd640 && pixv < 10'd480 && pixh[3:0] == 4'd14)
            rq.push_back('{int'(exp_rchar), cyc + 2});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic blank();
        pixh = 10'd700;
        pixv = 10'd500;
    endtask

    task automatic push_clear(input int start, input int n);
        for (int i = 0; i < n; i++) wq.push_back('{i, 8'h20, start + 1 + i});
    endtask

    int c0;

    initial begin
        clr = 1'b0;
        mem_init = 1'b1;
        cpu_wr_valid = 1'b0;
        cpu_wr_addr = '0;
        cpu_wr_data = '0;
        cpu_cls = 1'b0;
        blank();
        repeat (3) tick();
        clr = 1'b1;
        mem_init = 1'b0;
        settle();
        check("reset_mem_en", int'(mem_en), 0);
        check("reset_ready", int'(cpu_wr_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_render_valid", int'(render_valid), 0);

        // Render fetch of cell 41 (row 1, col 1)
        exp_rchar = 8'h41;
        pixv = 10'd16;
        for (int h = 16; h < 32; h++) begin
            tick();
            pixh = 10'(h);
            if (h == 30) begin
                settle();
                check("slot_en", int'(mem_en), 1);
                check("slot_we", int'(mem_we), 0);
                check("slot_addr", int'(mem_addr), 41);
            end
        end
        tick();
        blank();
        repeat (4) tick();

        // Single write, empty FIFO, blanking: written the cycle after acceptance
        tick();
        cpu_wr_valid = 1'b1;
        cpu_wr_addr = 12'd7;
        cpu_wr_data = 8'h37;
        wq.push_back('{7, 8'h37, cyc + 1});
        settle();
        check("single_ready", int'(cpu_wr_ready), 1);
        tick();
        cpu_wr_valid = 1'b0;
        repeat (3) tick();

        // Five writes while every cycle is a render slot: the fifth is refused
        tick();
        pixh = 10'd14;
        pixv = 10'd0;
        exp_rchar = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            cpu_wr_valid = 1'b1;
            cpu_wr_addr = 12'(100 + i);
            cpu_wr_data = 8'(8'h61 + i);
            settle();
            check($sformatf("fill_ready_%0d", i), int'(cpu_wr_ready), int'(i < 4));
            if (i < 4) wq.push_back('{100 + i, 8'h61 + i, -1});
        end
        tick();
        cpu_wr_valid = 1'b0;
        blank();
        repeat (6) tick();
        pixh = 10'd14;
        pixv = 10'd0;
        tick();
        blank();
        repeat (3) tick();
        settle();
        check("drain_busy", int'(busy), 0);
        check("drain_cell_103", int'(mem[103]), 8'h64);

        // Clear in vertical blanking: 1200 consecutive fill writes
        tick();
        pixh = 10'd100;
        pixv = 10'd500;
        cpu_cls = 1'b1;
        c0 = cyc;
        push_clear(c0, 1200);
        for (int k = 1; k <= 1200; k++) begin
            tick();
            cpu_cls = 1'b0;
        end
        settle();
        check("cls_busy_last", int'(busy), 1);
        tick();
        settle();
        check("cls_busy_done", int'(busy), 0);
        check("cls_cell_41", int'(mem[41]), 8'h20);
        check("cls_cell_1199", int'(mem[1199]), 8'h20);

        // Clear flushes three queued writes but keeps the same-cycle write
        tick();
        pixh = 10'd14;
        pixv = 10'd0;
        exp_rchar = 8'h20;
        for (int i = 0; i < 3; i++) begin
            tick();
            cpu_wr_valid = 1'b1;
            cpu_wr_addr = 12'(200 + i);
            cpu_wr_data = 8'(8'h71 + i);
        end
        tick();
        cpu_cls = 1'b1;
        cpu_wr_addr = 12'd5;
        cpu_wr_data = 8'h58;
        c0 = cyc;
        settle();
        check("cls_same_ready", int'(cpu_wr_ready), 1);
        push_clear(c0, 1200);
        wq.push_back('{5, 8'h58, c0 + 1201});
        tick();
        cpu_cls = 1'b0;
        cpu_wr_valid = 1'b0;
        blank();
        repeat (1204) tick();
        settle();
        check("flush_busy", int'(busy), 0);
        check("flush_cell_5", int'(mem[5]), 8'h58);
        check("flush_cell_200", int'(mem[200]), 8'h20);

        // Out-of-range write is popped without a memory access
        tick();
        cpu_wr_valid = 1'b1;
        cpu_wr_addr = 12'd1200;
        cpu_wr_data = 8'h11;
        settle();
        check("oor_ready", int'(cpu_wr_ready), 1);
        tick();
        cpu_wr_valid = 1'b0;
        settle();
        check("oor_busy", int'(busy), 1);
        check("oor_mem_en", int'(mem_en), 0);
        tick();
        settle();
        check("oor_busy_after", int'(busy), 0);

        // Reset in the middle of a clear, while cls_cnt is 500
        tick();
        cpu_cls = 1'b1;
        c0 = cyc;
        push_clear(c0, 501);
        for (int k = 1; k <= 500; k++) begin
            tick();
            cpu_cls = 1'b0;
        end
        tick();
        clr = 1'b0;
        settle();
        check("rst_mid_busy", int'(busy), 1);
        tick();
        clr = 1'b1;
        settle();
        check("rst_after_busy", int'(busy), 0);
        check("rst_after_mem_en", int'(mem_en), 0);
        check("rst_after_ready", int'(cpu_wr_ready), 1);
        repeat (20) tick();
        settle();
        check("wq_empty", wq.size(), 0);
        check("rq_empty", rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1);
    end

endmodule
